imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered immediate-generation stage between fetch and decode/execute.
- Takes an instruction beat (instr, pc, imm_src) over a valid/ready handshake and emits the XLEN-wide immediate one cycle later.
- Generalises the combinational extender:
  - XLEN 32/64.
  - New CSR-zimm format.
  - RV64 word-shift shamt handling.
  - Illegal-immediate flagging.
  - Two-entry skid buffer with flush.
- Sits in the NPC front end; its output feeds the ALU operand mux.

Parameters:
XLEN, 32, datapath/immediate width; legal values 32 or 64 (other values: elaboration error).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = !out_valid || out_ready.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous pipeline kill (redirect).
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
in_instr  in  32  raw instruction.
in_pc  in  XLEN  instruction address.
in_imm_src  in  3  InstrType format selector: I/U/J/S/B_TYPE, plus new Z_TYPE added to common.vh with a distinct code.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts.
out_instr  out  32  instruction passed through.
out_pc  out  XLEN  pc passed through.
out_imm  out  XLEN  generated immediate.
out_illegal  out  1  immediate encoding illegal for this XLEN or unknown imm_src.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid entry empty, out_instr/out_pc/out_imm=0, out_illegal=0. in_ready=1 from the first clock after release.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency 1 cycle from input transfer to out_valid.
  - Output fields are stable while out_valid && !out_ready.
- Immediate computed combinationally from in_* and registered with the beat. Sign extension is to XLEN (fill with instr[31]).
  - I: instr[31:20] sign-extended.
  - Shift-immediate, OP-IMM (0010011) with funct3 001/101:
    - XLEN=32: instr[24:20] zero-extended; out_illegal=1 if instr[25]=1.
    - XLEN=64: instr[25:20] zero-extended.
  - Word shift, XLEN=64 only, OP-IMM-32 (0011011) funct3 001/101: instr[24:20] zero-extended; illegal if instr[25]=1.
  - In all shift cases, instr[30] (arith select) is never part of imm.
  - U: {instr[31:12],12'b0} sign-extended to XLEN.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended.
  - S: {instr[31:25],instr[11:7]} sign-extended.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended.
  - Z: instr[19:15] zero-extended.
  - Any other imm_src code: imm=0, out_illegal=1.
- SKID=1 storage: main register (drives out_*) plus one skid entry.
  - Skid capture: a beat accepted while main is valid and out_ready=0 goes into skid.
  - in_ready is registered as !skid_valid.
  - When out_ready fires with skid valid, skid moves to main in the same edge.
  - Order is strictly FIFO; no beat is lost or duplicated.
- Simultaneous input accept and output drain with skid empty: the new beat goes directly to main; out_valid stays 1.
- SKID=0: single register; a new beat is loaded on the same edge the old one drains.
- flush (priority over all other events): next edge clears main and skid valid. Any beat presented that cycle is dropped. in_ready=1 next cycle.
- Data registers need no reset beyond the values listed; valid bits must reset.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately (async); out_illegal=0; in_ready=1 one cycle after release.
- XLEN=32, I_TYPE, 0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF. B_TYPE, 0xFE000EE3 -> out_imm=0xFFFFFFFC.
- Shifts:
  - srai 0x4030D093 -> imm=0x3.
  - slli 0x02009093, XLEN=32 -> out_illegal=1.
  - Same instruction, XLEN=64 -> imm=0x20, illegal=0.
  - XLEN=64, slliw 0x0200909B -> illegal=1.
- Z_TYPE, 0x000FD073 (csrrwi zimm=31) -> imm=0x1F. Unknown imm_src code -> imm=0, illegal=1.
- Backpressure, SKID=1:
  - Stream A,B,C with out_ready=0 for 3 cycles -> A held in main, B in skid, in_ready=0 so C stalls.
  - Raise out_ready -> outputs A,B,C in consecutive cycles, no gap, no duplicates.
- flush asserted with in_valid=1 and both entries full -> next cycle out_valid=0 and in_ready=1; the flushed beats never appear on the output.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready handshake.
// Optional two-entry skid buffer; output feeds the ALU operand mux.
package imm_gen_pkg;
  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] U_TYPE = 3'd1;
  localparam logic [2:0] J_TYPE = 3'd2;
  localparam logic [2:0] S_TYPE = 3'd3;
  localparam logic [2:0] B_TYPE = 3'd4;
  localparam logic [2:0] Z_TYPE = 3'd5;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
endpackage

module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            ill;
  } beat_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_sh;
  logic [XLEN-1:0] imm;
  logic            ill;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

  // instr[30] selects arithmetic shift and never reaches the shamt
  always_comb begin
    imm = '0;
    ill = 1'b0;
    unique case (in_imm_src)
      I_TYPE: begin
        if (opc == OP_IMM && is_sh) begin
          if (XLEN == 64) begin
            imm = XLEN'(in_instr[25:20]);
          end else begin
            imm = XLEN'(in_instr[24:20]);
            ill = in_instr[25];
          end
        end else if (XLEN == 64 && opc == OP_IMM32 && is_sh) begin
          imm = XLEN'(in_instr[24:20]);
          ill = in_instr[25];
        end else begin
          imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      U_TYPE: imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      J_TYPE: imm = XLEN'($signed({in_instr[31], in_instr[19:12],
                                   in_instr[20], in_instr[30:21],
                                   1'b0}));
      S_TYPE: imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      B_TYPE: imm = XLEN'($signed({in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8],
                                   1'b0}));
      Z_TYPE: imm = XLEN'(in_instr[19:15]);
      default: begin
        imm = '0;
        ill = 1'b1;
      end
    endcase
  end

  beat_t main_q, main_d;
  beat_t skid_q, skid_d;
  beat_t beat;
  logic  main_v_q, main_v_d;
  logic  skid_v_q, skid_v_d;
  logic  rdy_q;
  logic  in_fire;

  assign beat = '{instr: in_instr, pc: in_pc, imm: imm, ill: ill};

  assign in_ready = (SKID != 0) ? rdy_q : (!main_v_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = beat;
      end
    end else if (SKID != 0 && in_fire) begin
      skid_d   = beat;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN 32/64 with skid,
// XLEN 32 without skid, plus backpressure, flush and reset.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  logic [2:0]  src = '0;

  logic        r32, v32, l32;
  logic [31:0] oi32, p32, m32;
  logic        r64, v64, l64;
  logic [31:0] oi64;
  logic [63:0] p64, m64;
  logic        r0, v0, l0;
  logic [31:0] oi0, p0, m0;

  imm_gen_stage #(.XLEN(32), .SKID(1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32),
    .in_instr(instr), .in_pc(pc[31:0]), .in_imm_src(src),
    .out_valid(v32), .out_ready(out_ready),
    .out_instr(oi32), .out_pc(p32), .out_imm(m32),
    .out_illegal(l32)
  );

  imm_gen_stage #(.XLEN(64), .SKID(1)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .in_instr(instr), .in_pc(pc), .in_imm_src(src),
    .out_valid(v64), .out_ready(out_ready),
    .out_instr(oi64), .out_pc(p64), .out_imm(m64),
    .out_illegal(l64)
  );

  imm_gen_stage #(.XLEN(32), .SKID(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r0),
    .in_instr(instr), .in_pc(pc[31:0]), .in_imm_src(src),
    .out_valid(v0), .out_ready(out_ready),
    .out_instr(oi0), .out_pc(p0), .out_imm(m0),
    .out_illegal(l0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] mon_q[$];
  int          mon_c[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && v32 && out_ready) begin
      mon_q.push_back(oi32);
      mon_c.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic [31:0] ins);
    @(negedge clk);
    in_valid = v;
    src      = s;
    instr    = ins;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  s;
    logic [31:0] ins;
    logic [31:0] e32;
    logic        i32;
    logic [63:0] e64;
    logic        i64;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];
  int   base;

  initial begin
    tv[0]  = '{I_TYPE, 32'hFFF00093, 32'hFFFFFFFF, 1'b0,
               64'hFFFFFFFF_FFFFFFFF, 1'b0};
    tv[1]  = '{I_TYPE, 32'h7FF00093, 32'h000007FF, 1'b0,
               64'h7FF, 1'b0};
    tv[2]  = '{B_TYPE, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0,
               64'hFFFFFFFF_FFFFFFFC, 1'b0};
    tv[3]  = '{I_TYPE, 32'h4030D093, 32'h3, 1'b0, 64'h3, 1'b0};
    tv[4]  = '{I_TYPE, 32'h02009093, 32'h0, 1'b1, 64'h20, 1'b0};
    tv[5]  = '{I_TYPE, 32'h0200909B, 32'h20, 1'b0, 64'h0, 1'b1};
    tv[6]  = '{Z_TYPE, 32'h000FD073, 32'h1F, 1'b0, 64'h1F, 1'b0};
    tv[7]  = '{3'd7, 32'hFFF00093, 32'h0, 1'b1, 64'h0, 1'b1};
    tv[8]  = '{3'd6, 32'h12345037, 32'h0, 1'b1, 64'h0, 1'b1};
    tv[9]  = '{U_TYPE, 32'h12345037, 32'h12345000, 1'b0,
               64'h12345000, 1'b0};
    tv[10] = '{U_TYPE, 32'h80000037, 32'h80000000, 1'b0,
               64'hFFFFFFFF_80000000, 1'b0};
    tv[11] = '{J_TYPE, 32'hFFDFF0EF, 32'hFFFFFFFC, 1'b0,
               64'hFFFFFFFF_FFFFFFFC, 1'b0};
    tv[12] = '{S_TYPE, 32'hFE20AC23, 32'hFFFFFFF8, 1'b0,
               64'hFFFFFFFF_FFFFFFF8, 1'b0};
    tv[13] = '{I_TYPE, 32'h4010D09B, 32'h401, 1'b0, 64'h1, 1'b0};
    tv[14] = '{I_TYPE, 32'h4200D093, 32'h0, 1'b1, 64'h20, 1'b0};

    // power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(v32), 64'h0);
    chk("rst_imm", 64'(m64), 64'h0);
    chk("rst_ill", 64'(l32), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 64'(r32), 64'h1);

    // table of formats, one beat per cycle, never stalled
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      pc = 64'h8000_0000_0000_0000 + 64'(i * 4);
      drive(1'b1, tv[i].s, tv[i].ins);
      step();
      chk($sformatf("v32_%0d", i), 64'(v32), 64'h1);
      chk($sformatf("imm32_%0d", i), 64'(m32), 64'(tv[i].e32));
      chk($sformatf("ill32_%0d", i), 64'(l32), 64'(tv[i].i32));
      chk($sformatf("imm64_%0d", i), m64, tv[i].e64);
      chk($sformatf("ill64_%0d", i), 64'(l64), 64'(tv[i].i64));
      chk($sformatf("pc64_%0d", i), p64, pc);
      chk($sformatf("imm0_%0d", i), 64'(m0), 64'(tv[i].e32));
      chk($sformatf("ill0_%0d", i), 64'(l0), 64'(tv[i].i32));
    end
    drive(1'b0, I_TYPE, 32'h0);
    step();
    chk("drain_v", 64'(v32), 64'h0);

    // backpressure: A main, B skid, C stalled, then drain A,B,C
    base = mon_q.size();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    src       = I_TYPE;
    instr     = 32'h00100093;
    step();
    chk("bp_a_out", 64'(oi32), 64'h00100093);
    chk("bp_a_rdy", 64'(r32), 64'h1);
    chk("bp_nos_rdy", 64'(r0), 64'h0);
    drive(1'b1, I_TYPE, 32'h00200093);
    step();
    chk("bp_b_rdy", 64'(r32), 64'h0);
    chk("bp_b_out", 64'(oi32), 64'h00100093);
    drive(1'b1, I_TYPE, 32'h00300093);
    step();
    chk("bp_c_rdy", 64'(r32), 64'h0);
    chk("bp_c_out", 64'(oi64), 64'h00100093);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 64'(oi32), 64'h00200093);
    chk("bp_rdy_back", 64'(r32), 64'h1);
    step();
    chk("bp_out_c", 64'(oi32), 64'h00300093);
    chk("bp_out_c_v", 64'(v32), 64'h1);
    chk("bp_out_c_imm", m64, 64'h3);
    drive(1'b0, I_TYPE, 32'h0);
    step();
    chk("bp_empty", 64'(v32), 64'h0);
    chk("bp_count", 64'(mon_q.size()), 64'(base + 3));
    if (mon_q.size() == base + 3) begin
      chk("bp_ord0", 64'(mon_q[base]), 64'h00100093);
      chk("bp_ord1", 64'(mon_q[base + 1]), 64'h00200093);
      chk("bp_ord2", 64'(mon_q[base + 2]), 64'h00300093);
      chk("bp_gap1", 64'(mon_c[base + 1] - mon_c[base]), 64'h1);
      chk("bp_gap2", 64'(mon_c[base + 2] - mon_c[base + 1]), 64'h1);
    end

    // flush with both entries full and a beat on the input
    base = mon_q.size();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00400093;
    step();
    drive(1'b1, I_TYPE, 32'h00500093);
    step();
    chk("fl_full", 64'(r32), 64'h0);
    drive(1'b1, I_TYPE, 32'h00600093);
    flush = 1'b1;
    step();
    chk("fl_v32", 64'(v32), 64'h0);
    chk("fl_v64", 64'(v64), 64'h0);
    chk("fl_v0", 64'(v0), 64'h0);
    chk("fl_rdy", 64'(r32), 64'h1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_gone", 64'(mon_q.size()), 64'(base));
    drive(1'b1, Z_TYPE, 32'h0005D073);
    step();
    chk("fl_new_v", 64'(v32), 64'h1);
    chk("fl_new_imm", 64'(m32), 64'hB);
    drive(1'b0, I_TYPE, 32'h0);
    step();
    chk("fl_new_cnt", 64'(mon_q.size()), 64'(base + 1));

    // asynchronous reset while holding an illegal beat
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    src       = 3'd7;
    instr     = 32'h00000013;
    step();
    in_valid = 1'b0;
    chk("ar_pre_v", 64'(v32), 64'h1);
    chk("ar_pre_ill", 64'(l32), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_v", 64'(v32), 64'h0);
    chk("ar_ill", 64'(l32), 64'h0);
    chk("ar_v64", 64'(v64), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_rdy", 64'(r32), 64'h1);
    chk("ar_v_after", 64'(v32), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
